pipeline_hazard_controller: RTL

Central stall/flush arbiter for the five-stage pipeline: consumes the stall requests raised by the ID- and EX-stage forwarding units, control-flow redirects, data-memory wait and the WB-stage halt request, and drives the enable/flush of the PC and every pipeline register. It also keeps the halt state, saturating performance counters and a stall-deadlock watchdog. It sits in the top-level datapath beside the four pipeline registers.

---
 rtl/pipeline_hazard_controller_pkg.sv | 28 ++
 rtl/pipeline_hazard_controller_sat_counter.sv | 31 +++
 rtl/pipeline_hazard_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared hazard-control definitions: FSM state, the bundled enable/flush vector,
// and a helper used by the flush counter.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } HazardState;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } HazardCtrl;

  localparam HazardCtrl CTRL_FREEZE = '0;

  function automatic logic ctrl_any_flush(input HazardCtrl c);
    return c.if_id_flush | c.id_ex_flush | c.ex_mem_flush;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush arbiter for the five-stage pipeline, with sticky halt,
// saturating performance counters and a stall-deadlock watchdog.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_req_id,
  input  logic             stall_req_ex,
  input  logic             redirect_id,
  input  logic             redirect_ex,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic             deadlock,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output HazardState       state
);

  localparam int WD_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

  HazardState      state_q;
  HazardState      state_d;
  logic            deadlock_q;
  logic            deadlock_d;
  HazardCtrl       ctrl;
  logic            is_halted;
  logic            stalled;
  logic [WD_W-1:0] wd_cnt;

  assign is_halted = (state_q == HALTED);

  // Enables and flushes, highest priority first.
  always_comb begin
    ctrl = CTRL_FREEZE;
    if (is_halted || reset || mem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (stall_req_ex) begin
      ctrl.ex_mem_en    = 1'b1;
      ctrl.mem_wb_en    = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
    end else if (redirect_ex) begin
      ctrl.pc_en       = 1'b1;
      ctrl.if_id_en    = 1'b1;
      ctrl.id_ex_en    = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
      ctrl.mem_wb_en   = 1'b1;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (stall_req_id) begin
      ctrl.id_ex_en    = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
      ctrl.mem_wb_en   = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else begin
      ctrl.pc_en       = 1'b1;
      ctrl.if_id_en    = 1'b1;
      ctrl.id_ex_en    = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
      ctrl.mem_wb_en   = 1'b1;
      ctrl.if_id_flush = redirect_id;
    end
  end

  // The halting instruction retires in the same cycle it moves us to HALTED.
  always_comb begin
    state_d = state_q;
    if (!is_halted) begin
      if (halt_req && !mem_busy) begin
        state_d = HALTED;
      end else if (mem_busy) begin
        state_d = MEM_WAIT;
      end else begin
        state_d = RUN;
      end
    end
  end

  assign stalled = !ctrl.pc_en && !is_halted;

  always_comb begin
    deadlock_d = deadlock_q;
    if (stalled && (wd_cnt >= WD_LAST)) begin
      deadlock_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      deadlock_q <= deadlock_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cycles (
    .clk   (clk),
    .reset (reset),
    .inc   (stalled),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_count (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl_any_flush(ctrl)),
    .q     (flush_count)
  );

  // Any advancing cycle clears the watchdog; it neither counts nor clears while halted.
  sat_counter #(.W(WD_W)) u_watchdog (
    .clk   (clk),
    .reset (reset | ctrl.pc_en),
    .inc   (stalled),
    .q     (wd_cnt)
  );

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign halted       = is_halted;
  assign deadlock     = deadlock_q;
  assign state        = state_q;

endmodule
